// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: holds pending ops, captures CDB
// results by tag, and issues the oldest ready op over valid/ready.
module age_ordered_rs #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 8,
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [OP_W-1:0]           alloc_op,
  input  logic [TAG_W-1:0]          alloc_dest_tag,
  input  logic                      alloc_src1_busy,
  input  logic [TAG_W-1:0]          alloc_src1_tag,
  input  logic [DATA_W-1:0]         alloc_src1_val,
  input  logic                      alloc_src2_busy,
  input  logic [TAG_W-1:0]          alloc_src2_tag,
  input  logic [DATA_W-1:0]         alloc_src2_val,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [OP_W-1:0]           issue_op,
  output logic [TAG_W-1:0]          issue_dest_tag,
  output logic [DATA_W-1:0]         issue_src1,
  output logic [DATA_W-1:0]         issue_src2,
  output logic [CNT_W-1:0]          num_free
);

  localparam int AGE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = AGE_W;

  logic [DEPTH-1:0]  r_valid;
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [DEPTH-1:0]  r_b1;
  logic [DEPTH-1:0]  r_b2;
  logic [TAG_W-1:0]  r_t1   [DEPTH];
  logic [TAG_W-1:0]  r_t2   [DEPTH];
  logic [DATA_W-1:0] r_v1   [DEPTH];
  logic [DATA_W-1:0] r_v2   [DEPTH];
  logic [AGE_W-1:0]  r_age  [DEPTH];

  logic [DEPTH-1:0]  w_rdy;
  logic              w_any;
  logic [IDX_W-1:0]  w_sel;
  logic [AGE_W-1:0]  w_sel_age;
  logic [IDX_W-1:0]  w_free_idx;
  logic [CNT_W-1:0]  w_cnt;
  logic [AGE_W-1:0]  w_new_age;
  logic              w_fire_alloc;
  logic              w_fire_iss;
  logic [DEPTH-1:0]  w_h1;
  logic [DEPTH-1:0]  w_h2;
  logic [DATA_W-1:0] w_d1   [DEPTH];
  logic [DATA_W-1:0] w_d2   [DEPTH];
  logic [DATA_W:0]   w_a1;
  logic [DATA_W:0]   w_a2;

  // Returns {hit, data}; scanning high to low lets port 0 win ties.
  function automatic logic [DATA_W:0] f_cdb(
    input logic [TAG_W-1:0]          t,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  tg,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = NUM_CDB-1; p >= 0; p--) begin
      if (v[p] && tg[p*TAG_W +: TAG_W] == t)
        res = {1'b1, d[p*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  always_comb begin
    w_h1 = '0;
    w_h2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {w_h1[i], w_d1[i]} = f_cdb(r_t1[i], cdb_valid, cdb_tag, cdb_data);
      {w_h2[i], w_d2[i]} = f_cdb(r_t2[i], cdb_valid, cdb_tag, cdb_data);
    end
    w_a1 = f_cdb(alloc_src1_tag, cdb_valid, cdb_tag, cdb_data);
    w_a2 = f_cdb(alloc_src2_tag, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    w_rdy     = '0;
    w_any     = 1'b0;
    w_sel     = '0;
    w_sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i] = r_valid[i] && !r_b1[i] && !r_b2[i];
      if (w_rdy[i] && (!w_any || r_age[i] < w_sel_age)) begin
        w_any     = 1'b1;
        w_sel     = IDX_W'(i);
        w_sel_age = r_age[i];
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_cnt      = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
      w_cnt = w_cnt + CNT_W'(r_valid[i]);
    end
  end

  assign num_free     = CNT_W'(DEPTH) - w_cnt;
  assign alloc_ready  = (num_free != '0);
  assign w_fire_alloc = alloc_valid && alloc_ready;
  assign w_fire_iss   = w_any && issue_ready;
  // Age counts survivors, so an issuing entry is subtracted out.
  assign w_new_age    = AGE_W'(w_cnt) - AGE_W'(w_fire_iss);

  assign issue_valid    = w_any;
  assign issue_op       = w_any ? r_op[w_sel]   : '0;
  assign issue_dest_tag = w_any ? r_dest[w_sel] : '0;
  assign issue_src1     = w_any ? r_v1[w_sel]   : '0;
  assign issue_src2     = w_any ? r_v2[w_sel]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_b1    <= '0;
      r_b2    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]   <= '0;
        r_dest[i] <= '0;
        r_t1[i]   <= '0;
        r_t2[i]   <= '0;
        r_v1[i]   <= '0;
        r_v2[i]   <= '0;
        r_age[i]  <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          if (r_b1[i] && w_h1[i]) begin
            r_b1[i] <= 1'b0;
            r_v1[i] <= w_d1[i];
          end
          if (r_b2[i] && w_h2[i]) begin
            r_b2[i] <= 1'b0;
            r_v2[i] <= w_d2[i];
          end
          if (w_fire_iss && w_sel == IDX_W'(i))
            r_valid[i] <= 1'b0;
          else if (w_fire_iss && r_age[i] > w_sel_age)
            r_age[i] <= r_age[i] - 1'b1;
        end
      end
      if (w_fire_alloc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_op[w_free_idx]    <= alloc_op;
        r_dest[w_free_idx]  <= alloc_dest_tag;
        r_t1[w_free_idx]    <= alloc_src1_tag;
        r_t2[w_free_idx]    <= alloc_src2_tag;
        r_age[w_free_idx]   <= w_new_age;
        r_b1[w_free_idx]    <= alloc_src1_busy && !w_a1[DATA_W];
        r_b2[w_free_idx]    <= alloc_src2_busy && !w_a2[DATA_W];
        r_v1[w_free_idx]    <= alloc_src1_busy ? w_a1[DATA_W-1:0]
                                               : alloc_src1_val;
        r_v2[w_free_idx]    <= alloc_src2_busy ? w_a2[DATA_W-1:0]
                                               : alloc_src2_val;
      end
    end
  end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: fill, wakeup order, bypass,
// back-pressure, CDB priority, flush, age ordering and async reset.
module tb_age_ordered_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [7:0]  alloc_op;
  logic [3:0]  alloc_dest_tag;
  logic        alloc_src1_busy;
  logic [3:0]  alloc_src1_tag;
  logic [31:0] alloc_src1_val;
  logic        alloc_src2_busy;
  logic [3:0]  alloc_src2_tag;
  logic [31:0] alloc_src2_val;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_op;
  logic [3:0]  issue_dest_tag;
  logic [31:0] issue_src1;
  logic [31:0] issue_src2;
  logic [3:0]  num_free;

  int checks = 0;
  int errors = 0;

  age_ordered_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_dest_tag(alloc_dest_tag),
    .alloc_src1_busy(alloc_src1_busy), .alloc_src1_tag(alloc_src1_tag),
    .alloc_src1_val(alloc_src1_val),
    .alloc_src2_busy(alloc_src2_busy), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src2_val(alloc_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dest_tag(issue_dest_tag),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .num_free(num_free)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_op = 0; alloc_dest_tag = 0;
    alloc_src1_busy = 0; alloc_src1_tag = 0; alloc_src1_val = 0;
    alloc_src2_busy = 0; alloc_src2_tag = 0; alloc_src2_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_ready = 0;
  endtask

  task automatic set_alloc(input logic [7:0] op, input logic [3:0] dt,
                           input logic b1, input logic [3:0] t1,
                           input logic [31:0] v1,
                           input logic b2, input logic [3:0] t2,
                           input logic [31:0] v2);
    alloc_valid = 1; alloc_op = op; alloc_dest_tag = dt;
    alloc_src1_busy = b1; alloc_src1_tag = t1; alloc_src1_val = v1;
    alloc_src2_busy = b2; alloc_src2_tag = t2; alloc_src2_val = v2;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #3;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid);
    end
    checks++;
    if (num_free !== 4'd8) begin
      errors++; $display("FAIL reset_num_free got %0d exp 8", num_free);
    end
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready);
    end
    checks++;
    if (issue_dest_tag !== 4'd0 || issue_src1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_issue_zero got %h/%h exp 0/0",
               issue_dest_tag, issue_src1);
    end
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_fill();
    idle();
    for (int k = 0; k < 8; k++) begin
      set_alloc(8'(k + 16), 4'(k + 1), 0, 0, 32'(k), 0, 0, 32'(2 * k));
      tick();
      checks++;
      if (num_free !== 4'(7 - k)) begin
        errors++;
        $display("FAIL fill_num_free[%0d] got %0d exp %0d", k, num_free, 7 - k);
      end
      if (k == 0) begin
        checks++;
        if (issue_valid !== 1'b1) begin
          errors++; $display("FAIL alloc_latency got %b exp 1", issue_valid);
        end
      end
    end
    alloc_valid = 0;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL full_alloc_ready got %b exp 0", alloc_ready);
    end
    checks++;
    if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd1 ||
        issue_op !== 8'd16) begin
      errors++;
      $display("FAIL full_oldest got v=%b tag=%0d op=%0d exp v=1 tag=1 op=16",
               issue_valid, issue_dest_tag, issue_op);
    end
  endtask

  task automatic test_full_issue();
    set_alloc(8'hEE, 4'd9, 0, 0, 0, 0, 0, 0);
    issue_ready = 1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL full_issue_ready got %b exp 0", alloc_ready);
    end
    tick();
    alloc_valid = 0;
    issue_ready = 0;
    checks++;
    if (num_free !== 4'd1 || alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_issue_free got %0d/%b exp 1/1", num_free, alloc_ready);
    end
    issue_ready = 1;
    for (int k = 2; k <= 8; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_dest_tag !== 4'(k) ||
          issue_src2 !== 32'(2 * (k - 1))) begin
        errors++;
        $display("FAIL drain[%0d] got v=%b tag=%0d s2=%0d exp v=1 tag=%0d s2=%0d",
                 k, issue_valid, issue_dest_tag, issue_src2, k, 2 * (k - 1));
      end
      tick();
    end
    issue_ready = 0;
    checks++;
    if (issue_valid !== 1'b0 || num_free !== 4'd8) begin
      errors++;
      $display("FAIL drain_empty got v=%b free=%0d exp v=0 free=8",
               issue_valid, num_free);
    end
  endtask

  task automatic test_wakeup_order();
    idle();
    set_alloc(8'h0A, 4'd10, 1, 4'd3, 0, 0, 0, 32'd2);
    tick();
    set_alloc(8'h0B, 4'd11, 0, 0, 32'h11, 0, 0, 32'h22);
    issue_ready = 1;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++; $display("FAIL wake_busy_hold got %b exp 0", issue_valid);
    end
    tick();
    alloc_valid = 0;
    cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_data = {32'hDEAD, 32'h0};
    checks++;
    if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd11) begin
      errors++;
      $display("FAIL wake_b_first got v=%b tag=%0d exp v=1 tag=11",
               issue_valid, issue_dest_tag);
    end
    tick();
    cdb_valid = 0;
    checks++;
    if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd10 ||
        issue_src1 !== 32'hDEAD || issue_src2 !== 32'd2) begin
      errors++;
      $display("FAIL wake_a_next got v=%b tag=%0d s1=%h s2=%h exp 1/10/dead/2",
               issue_valid, issue_dest_tag, issue_src1, issue_src2);
    end
    tick();
    issue_ready = 0;
    checks++;
    if (issue_valid !== 1'b0 || num_free !== 4'd8) begin
      errors++;
      $display("FAIL wake_empty got v=%b free=%0d exp 0/8", issue_valid, num_free);
    end
  endtask

  task automatic test_alloc_bypass();
    idle();
    set_alloc(8'h33, 4'd4, 0, 0, 32'd7, 1, 4'd5, 0);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_data = {32'h0, 32'h1234};
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_src2 !== 32'h1234 ||
        issue_src1 !== 32'd7 || issue_op !== 8'h33) begin
      errors++;
      $display("FAIL bypass got v=%b s1=%h s2=%h op=%h exp 1/7/1234/33",
               issue_valid, issue_src1, issue_src2, issue_op);
    end
    issue_ready = 1;
    tick();
    issue_ready = 0;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_drain got %b exp 0", issue_valid);
    end
  endtask

  task automatic test_cdb_priority();
    idle();
    set_alloc(8'h44, 4'd6, 1, 4'd7, 0, 0, 0, 32'd1);
    tick();
    alloc_valid = 0;
    cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7};
    cdb_data = {32'hBBBB, 32'hAAAA};
    tick();
    cdb_valid = 0;
    checks++;
    if (issue_valid !== 1'b1 || issue_src1 !== 32'hAAAA) begin
      errors++;
      $display("FAIL cdb_prio got v=%b s1=%h exp 1/aaaa", issue_valid, issue_src1);
    end
    issue_ready = 1;
    tick();
    issue_ready = 0;
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 5; k++) begin
      set_alloc(8'(k), 4'(k + 1), 0, 0, 0, 0, 0, 0);
      tick();
    end
    alloc_valid = 0;
    checks++;
    if (num_free !== 4'd3 || issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush got free=%0d v=%b exp 3/1", num_free, issue_valid);
    end
    set_alloc(8'h55, 4'd15, 0, 0, 0, 0, 0, 0);
    flush = 1;
    tick();
    idle();
    checks++;
    if (num_free !== 4'd8 || issue_valid !== 1'b0 || issue_dest_tag !== 4'd0) begin
      errors++;
      $display("FAIL flush got free=%0d v=%b tag=%0d exp 8/0/0",
               num_free, issue_valid, issue_dest_tag);
    end
    tick();
    checks++;
    if (num_free !== 4'd8) begin
      errors++; $display("FAIL flush_drop got %0d exp 8", num_free);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    set_alloc(8'h01, 4'd14, 0, 0, 0, 0, 0, 0);
    tick();
    set_alloc(8'h02, 4'd12, 1, 4'd9, 0, 0, 0, 32'd5);
    issue_ready = 1;
    checks++;
    if (issue_dest_tag !== 4'd14) begin
      errors++; $display("FAIL b2b_x got %0d exp 14", issue_dest_tag);
    end
    tick();
    checks++;
    if (num_free !== 4'd7) begin
      errors++; $display("FAIL b2b_free got %0d exp 7", num_free);
    end
    set_alloc(8'h03, 4'd13, 0, 0, 32'd3, 0, 0, 32'd4);
    tick();
    idle();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h99};
    checks++;
    if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd13 || num_free !== 4'd6) begin
      errors++;
      $display("FAIL b2b_z_only got v=%b tag=%0d free=%0d exp 1/13/6",
               issue_valid, issue_dest_tag, num_free);
    end
    tick();
    cdb_valid = 0;
    checks++;
    if (issue_dest_tag !== 4'd12 || issue_src1 !== 32'h99) begin
      errors++;
      $display("FAIL b2b_age_order got tag=%0d s1=%h exp 12/99",
               issue_dest_tag, issue_src1);
    end
    issue_ready = 1;
    tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd13) begin
      errors++;
      $display("FAIL b2b_second got v=%b tag=%0d exp 1/13",
               issue_valid, issue_dest_tag);
    end
    tick();
    issue_ready = 0;
    checks++;
    if (issue_valid !== 1'b0 || num_free !== 4'd8) begin
      errors++;
      $display("FAIL b2b_empty got v=%b free=%0d exp 0/8", issue_valid, num_free);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    set_alloc(8'h66, 4'd2, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    #2;
    rst = 0;
    #1;
    checks++;
    if (issue_valid !== 1'b0 || num_free !== 4'd8 || issue_op !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got v=%b free=%0d op=%h exp 0/8/00",
               issue_valid, num_free, issue_op);
    end
    tick();
    rst = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_issue();
    test_wakeup_order();
    test_alloc_bypass();
    test_cdb_priority();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
